// File: rtl/instruction_queue_if.sv
// instruction_queue_if: fetch-side and decode-side handshake bundle for the instruction queue.
interface instruction_queue_if #(parameter int iq_index_bits = 3);
    logic [31:0] instruction_fetch;
    logic [31:0] PC_fetch;
    logic load_iq_fetch;
    logic iq_full;
    logic [31:0] instruction_iq_head;
    logic [31:0] PC_iq_head;
    logic load_dec_iq;
    logic full_dec;
    logic flush;
    logic [iq_index_bits:0] iq_count;
    modport master (
        output instruction_fetch, PC_fetch, load_iq_fetch, full_dec, flush,
        input iq_full, instruction_iq_head, PC_iq_head, load_dec_iq, iq_count
    );
    modport slave (
        input instruction_fetch, PC_fetch, load_iq_fetch, full_dec, flush,
        output iq_full, instruction_iq_head, PC_iq_head, load_dec_iq, iq_count
    );
endinterface

// File: rtl/instruction_queue.sv
// instruction_queue: circular show-ahead FIFO of {instruction, PC} between fetch and decode.
module instruction_queue #(
    parameter int iq_size = 8,
    parameter int iq_index_bits = 3
) (
    input logic clk,
    input logic rst,
    instruction_queue_if.slave q
);
    logic [63:0] mem [iq_size];
    logic [iq_index_bits-1:0] head_ptr, tail_ptr;
    logic [iq_index_bits:0] count;
    logic push, pop;
    assign q.iq_full = count == (iq_index_bits+1)'(iq_size);
    assign q.load_dec_iq = count != '0 && !q.flush;
    assign q.iq_count = count;
    assign {q.instruction_iq_head, q.PC_iq_head} = count != '0 ? mem[head_ptr] : '0;
    // No full-bypass: a pop while full still blocks the same-cycle push.
    assign push = q.load_iq_fetch && !q.iq_full && !q.flush;
    assign pop = q.load_dec_iq && !q.full_dec;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count <= '0;
        end else if (q.flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop) head_ptr <= head_ptr + 1'b1;
            count <= count + (iq_index_bits+1)'(push) - (iq_index_bits+1)'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[tail_ptr] <= {q.instruction_fetch, q.PC_fetch};
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_instruction_queue;
    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;
    instruction_queue_if #(.iq_index_bits(3)) q ();
    instruction_queue #(.iq_size(8), .iq_index_bits(3)) dut (.clk(clk), .rst(rst), .q(q));
    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [63:0] exp_q [$];
    bit last_push = 0;
    int n;
    bit e_full, e_load, do_pop, do_push;
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    // Scoreboard monitor: samples at negedge, predicts the coming edge's push/pop.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            last_push = 0;
            chk("rst_count", q.iq_count, 0);
            chk("rst_load", q.load_dec_iq, 0);
            chk("rst_head", {q.instruction_iq_head, q.PC_iq_head}, 0);
        end else begin
            n = exp_q.size();
            e_full = n == 8;
            e_load = n != 0 && !q.flush;
            chk("iq_count", q.iq_count, n);
            chk("iq_full", q.iq_full, e_full);
            chk("load_dec_iq", q.load_dec_iq, e_load);
            chk("head", {q.instruction_iq_head, q.PC_iq_head}, n != 0 ? exp_q[0] : 64'd0);
            do_pop = e_load && !q.full_dec;
            do_push = q.load_iq_fetch && !e_full && !q.flush;
            if (q.flush) exp_q.delete();
            else begin
                if (do_pop) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
                if (do_push) exp_q.push_back({q.instruction_fetch, q.PC_fetch});
            end
            last_push = do_push;
        end
    end
    task automatic drive(bit ld, logic [31:0] ins, logic [31:0] pc, bit fd, bit fl);
        @(posedge clk);
        #1;
        q.load_iq_fetch = ld;
        q.instruction_fetch = ins;
        q.PC_fetch = pc;
        q.full_dec = fd;
        q.flush = fl;
    endtask
    initial begin
        int k;
        int p0;
        q.load_iq_fetch = 0;
        q.instruction_fetch = 0;
        q.PC_fetch = 0;
        q.full_dec = 0;
        q.flush = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        // basic push then pop
        drive(1, 32'h13, 32'h60, 1, 0);
        drive(0, 0, 0, 0, 0);
        #3;
        chk("basic_load", q.load_dec_iq, 1);
        chk("basic_head", {q.instruction_iq_head, q.PC_iq_head}, {32'h13, 32'h60});
        chk("basic_count", q.iq_count, 1);
        drive(0, 0, 0, 0, 0);
        #3;
        chk("basic_empty_load", q.load_dec_iq, 0);
        chk("basic_empty_head", {q.instruction_iq_head, q.PC_iq_head}, 0);
        // fill under stall, 9th push ignored
        for (int i = 0; i < 9; i++) drive(1, 32'h1000 + i, 32'(i * 4), 1, 0);
        #3;
        chk("fill_count", q.iq_count, 8);
        chk("fill_full", q.iq_full, 1);
        drive(0, 0, 0, 1, 0);
        #3;
        chk("fill_9th_ignored", q.iq_count, 8);
        chk("fill_head_pc", q.PC_iq_head, 0);
        // full with pop: push blocked, then push+pop holds count
        drive(1, 32'h2000, 32'h24, 0, 0);
        #3;
        chk("fullpop_pre", q.iq_count, 8);
        drive(1, 32'h2000, 32'h24, 0, 0);
        #3;
        chk("fullpop_count", q.iq_count, 7);
        chk("fullpop_notfull", q.iq_full, 0);
        drive(0, 0, 0, 1, 0);
        #3;
        chk("pushpop_count", q.iq_count, 7);
        chk("pushpop_head_pc", q.PC_iq_head, 32'h08);
        repeat (9) drive(0, 0, 0, 0, 0);
        #3;
        chk("drain1_count", q.iq_count, 0);
        // streaming across pointer wrap with toggling back-pressure
        k = 0;
        p0 = pops;
        for (int c = 0; c < 200 && k < 20; c++) begin
            drive(1, 32'h3000 + k, 32'h100 + 32'(4 * k), c[0], 0);
            @(negedge clk);
            #1;
            if (last_push) k++;
        end
        chk("wrap_accepted", k, 20);
        repeat (10) drive(0, 0, 0, 0, 0);
        #3;
        chk("wrap_drain_count", q.iq_count, 0);
        chk("wrap_pops", pops - p0, 20);
        // flush with simultaneous push
        for (int i = 0; i < 5; i++) drive(1, 32'h4000 + i, 32'h200 + 32'(4 * i), 1, 0);
        drive(1, 32'h4444, 32'h300, 1, 1);
        #3;
        chk("flush_load", q.load_dec_iq, 0);
        chk("flush_pre_count", q.iq_count, 5);
        drive(0, 0, 0, 1, 0);
        #3;
        chk("flush_count", q.iq_count, 0);
        chk("flush_head", {q.instruction_iq_head, q.PC_iq_head}, 0);
        drive(1, 32'h5555, 32'h400, 1, 0);
        drive(0, 0, 0, 1, 0);
        #3;
        chk("postflush_count", q.iq_count, 1);
        chk("postflush_head", {q.instruction_iq_head, q.PC_iq_head}, {32'h5555, 32'h400});
        repeat (2) drive(0, 0, 0, 0, 0);
        // asynchronous reset between edges
        for (int i = 0; i < 4; i++) drive(1, 32'h6000 + i, 32'h500 + 32'(4 * i), 1, 0);
        drive(0, 0, 0, 1, 0);
        chk("areset_pre_count", q.iq_count, 4);
        #1 rst = 0;
        #1;
        chk("areset_count", q.iq_count, 0);
        chk("areset_load", q.load_dec_iq, 0);
        chk("areset_full", q.iq_full, 0);
        chk("areset_head", {q.instruction_iq_head, q.PC_iq_head}, 0);
        @(posedge clk);
        #1 rst = 1;
        drive(1, 32'h7777, 32'h600, 1, 0);
        drive(0, 0, 0, 1, 0);
        #3;
        chk("post_reset_count", q.iq_count, 1);
        chk("post_reset_head", {q.instruction_iq_head, q.PC_iq_head}, {32'h7777, 32'h600});
        repeat (3) drive(0, 0, 0, 0, 0);
        #3;
        chk("final_count", q.iq_count, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
